// File: rtl/timer_ctrl.sv
// Run controller for the 7-segment countdown timer.
// Owns the one-second prescale counter and the remaining time, kept as BCD mm:ss.
module timer_ctrl #(
    parameter logic [31:0] TICK_PERIOD = 32'd50000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        clear,
    input  logic [6:0]  load_min,
    input  logic [5:0]  load_sec,
    output logic [31:0] counter,
    output logic        running,
    output logic [7:0]  min_bcd,
    output logic [7:0]  sec_bcd,
    output logic        done,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] counter_q, counter_d;
    logic [7:0]  min_q, min_d;
    logic [7:0]  sec_q, sec_d;
    logic        running_q, done_q;

    logic [6:0]  min_clamp;
    logic [6:0]  sec_clamp;
    logic        preset_nz;
    logic        wrap;
    logic [15:0] dec_time_v;

    function automatic logic [7:0] bin2bcd(input logic [6:0] v);
        logic [6:0] rem;
        logic [3:0] tens;
        rem  = v;
        tens = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, 4'(rem)};
    endfunction

    // Only called with a non-zero time, so the minutes borrow never underflows.
    function automatic logic [15:0] dec_time(input logic [7:0] m, input logic [7:0] s);
        logic [7:0] m_n;
        logic [7:0] s_n;
        m_n = m;
        s_n = s;
        if (s[3:0] != 4'd0) begin
            s_n = {s[7:4], s[3:0] - 4'd1};
        end else if (s[7:4] != 4'd0) begin
            s_n = {s[7:4] - 4'd1, 4'd9};
        end else begin
            s_n = 8'h59;
            if (m[3:0] != 4'd0) begin
                m_n = {m[7:4], m[3:0] - 4'd1};
            end else if (m[7:4] != 4'd0) begin
                m_n = {m[7:4] - 4'd1, 4'd9};
            end
        end
        return {m_n, s_n};
    endfunction

    assign min_clamp  = (load_min > 7'd99) ? 7'd99 : load_min;
    assign sec_clamp  = ({1'b0, load_sec} > 7'd59) ? 7'd59 : {1'b0, load_sec};
    assign preset_nz  = (min_clamp != 7'd0) || (sec_clamp != 7'd0);
    assign wrap       = (counter_q == TICK_PERIOD - 32'd1);
    assign dec_time_v = dec_time(min_q, sec_q);

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        min_d     = min_q;
        sec_d     = sec_q;
        if (clear) begin
            state_d   = IDLE;
            counter_d = 32'd0;
            min_d     = 8'h00;
            sec_d     = 8'h00;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start && preset_nz) begin
                        state_d   = RUN;
                        counter_d = 32'd0;
                        min_d     = bin2bcd(min_clamp);
                        sec_d     = bin2bcd(sec_clamp);
                    end
                end
                RUN: begin
                    // start outranks pause even though start itself does nothing in RUN
                    if (pause && !start) begin
                        state_d = PAUSE;
                    end else if (wrap) begin
                        counter_d = 32'd0;
                        min_d     = dec_time_v[15:8];
                        sec_d     = dec_time_v[7:0];
                        if (dec_time_v == 16'h0000) begin
                            state_d = DONE;
                        end
                    end else begin
                        counter_d = counter_q + 32'd1;
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            counter_q <= 32'd0;
            min_q     <= 8'h00;
            sec_q     <= 8'h00;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            running_q <= (state_d == RUN);
            done_q    <= (state_d == DONE);
        end
    end

    assign state   = state_q;
    assign counter = counter_q;
    assign min_bcd = min_q;
    assign sec_bcd = sec_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Run controller for the 7-segment countdown timer. Owns the prescale counter that the one-second pulse logic compares against, sequences it through idle/run/pause/done under push-button commands, and keeps the remaining time as BCD minutes and seconds for the display driver. Sits between the debounced button pulses and the pulse generator / 7-segment mux.

## Interface

Parameters:
- TICK_PERIOD, 32'd50000000, clock cycles per one-second tick (legal range ≥ 2)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; forces every register to its reset value
- start  in  1  single-cycle command: load-and-run from IDLE/DONE, resume from PAUSE
- pause  in  1  single-cycle command: freeze countdown while in RUN
- clear  in  1  single-cycle command: abort to IDLE, zero time
- load_min  in  7  preset minutes, binary 0-99 (values >99 clamp to 99)
- load_sec  in  6  preset seconds, binary 0-59 (values >59 clamp to 59)
- counter  out  32  prescale count, 0..TICK_PERIOD-1, exported to pulse logic
- running  out  1  high in RUN
- min_bcd  out  8  remaining minutes, {tens, ones} BCD
- sec_bcd  out  8  remaining seconds, {tens, ones} BCD
- done  out  1  high in DONE (level)
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3

## Operation

- Reset values: state IDLE, counter 0, min_bcd 8'h00, sec_bcd 8'h00, done 0, running 0.
- Command priority when several are high in one cycle: clear > start > pause.
- IDLE: start with clamped preset ≠ 00:00 → load min_bcd/sec_bcd (binary→BCD), counter 0, → RUN. Start with preset 00:00 → ignored, stays IDLE. pause ignored.
- RUN: counter increments each cycle; at TICK_PERIOD-1 it wraps to 0 and the time decrements by one second on the same edge. pause → PAUSE, counter and time held. start ignored.
- Decrement: sec ones 0 → 9 with borrow into sec tens; sec 00 → 59 with borrow into minutes; minutes decrement in BCD the same way. Decrement producing 00:00 → DONE on that edge, counter 0.
- PAUSE: all held. start → RUN (counter resumes from held value, time not reloaded). pause ignored.
- DONE: time held at 00:00, done=1. start → reload preset as from IDLE (00:00 preset → stays DONE). pause ignored.
- clear in any state → IDLE, counter 0, time 00:00, done 0.
- All outputs are registered; running and done are decodes of the state register.

## Timing

- Commands sampled on rising edge; state/outputs update on that edge (1-cycle latency).
- First decrement occurs exactly TICK_PERIOD cycles after the start edge; subsequent decrements every TICK_PERIOD cycles of RUN time (PAUSE cycles not counted).
- pause in the same cycle counter = TICK_PERIOD-1: pause wins, decrement suppressed, counter holds at TICK_PERIOD-1; first RUN cycle after resume performs the wrap and decrement.
- clear on the wrap cycle: clear wins, no decrement.
- Reset asserted mid-count: immediate return to reset values independent of clock; after release, block waits in IDLE for start.
- counter never reaches TICK_PERIOD; an external compare against TICK_PERIOD-1 yields one pulse per second.

## Test plan

With TICK_PERIOD=4:
- Reset then start, load_min=0, load_sec=3 → RUN; sec_bcd 03→02→01→00 at 4, 8, 12 cycles after start; state=DONE, done=1 at cycle 12; counter=0.
- Borrow: load 1:00, start → after 4 cycles min_bcd=00, sec_bcd=8'h59; load 10:00 → 09:59.
- Pause at counter=2 for 10 cycles, then start → counter resumes from 2; decrement 2 RUN cycles later; time unchanged during pause.
- Pause and start and clear asserted together in RUN → IDLE, time 00:00; pause on wrap cycle → no decrement, decrement on first cycle after resume.
- Start with load 0:00 in IDLE → stays IDLE; load_sec=63, load_min=120 → loads 99:59.
- Assert reset asynchronously mid-RUN (between edges) → all outputs reset immediately; start from DONE reloads preset and runs.
